irq_pending_latch: RTL and testbench

//  Front-end for the 4:2 priority encoder: captures asynchronous request lines,

---
 rtl/irq_pending_latch.sv | 128 ++++++++++++
 tb/tb_irq_pending_latch.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_pending_latch.sv
// irq_pending_latch
//   Captures asynchronous request lines, synchronises them, qualifies each line
//   as edge or level, and holds the result in sticky pending bits. The
//   highest-priority enabled pending index is presented to the consumer over a
//   valid/ack handshake. Bit N-1 has the highest priority.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_in     raw request lines, asynchronous to clk
//   edge_sel   per line: 1 = rising-edge event, 0 = level event
//   mask       per line: 1 = may be presented, 0 = held pending only
//   irq_ack    consumer accepts the presented index (one-cycle pulse)
//   ovf_clr    clears all overflow bits
//   irq_valid  an index is being presented
//   irq_idx    presented index, stable while irq_valid is high
//   pend       pending register, visible regardless of mask
//   ovf        sticky: event arrived while that line was already pending
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | nothing presented; load highest enabled pending index if any
// PRESENT | irq_idx held and irq_valid high until irq_ack
module irq_pending_latch #(
  parameter int N           = 4,
  parameter int IDX_W       = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_in,
  input  logic [N-1:0]     edge_sel,
  input  logic [N-1:0]     mask,
  input  logic             irq_ack,
  input  logic             ovf_clr,
  output logic             irq_valid,
  output logic [IDX_W-1:0] irq_idx,
  output logic [N-1:0]     pend,
  output logic [N-1:0]     ovf
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t           state_q, state_nxt;
  logic [N-1:0]     sync_q [SYNC_STAGES];
  logic [N-1:0]     req_s, req_d;
  logic [N-1:0]     evt;
  logic [N-1:0]     clr_vec;
  logic [N-1:0]     active;
  logic [N-1:0]     pend_nxt, ovf_nxt;
  logic [IDX_W-1:0] idx_q, idx_nxt, hi_idx;

  // Synchroniser chain plus one extra delay for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      req_d <= '0;
    end else begin
      sync_q[0] <= req_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      req_d <= req_s;
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  // edge_sel is used combinationally so a mode change acts the same cycle.
  assign evt = (edge_sel & req_s & ~req_d) | (~edge_sel & req_s);

  // Only an accepted grant clears a pend bit; ack outside PRESENT is ignored.
  always_comb begin
    clr_vec = '0;
    if (state_q == PRESENT && irq_ack) clr_vec[irq_idx] = 1'b1;
  end

  // Set wins over clear so an event coinciding with the ack is not lost.
  assign pend_nxt = (pend & ~clr_vec) | evt;
  // A bit being cleared this cycle simply re-pends; that is not an overflow.
  assign ovf_nxt  = (ovf & ~{N{ovf_clr}}) | (evt & pend & ~clr_vec);

  assign active = pend & mask;

  always_comb begin
    hi_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (active[i]) hi_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_nxt = state_q;
    idx_nxt   = idx_q;
    case (state_q)
      IDLE: begin
        if (|active) begin
          idx_nxt   = hi_idx;
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (irq_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pend    <= '0;
      ovf     <= '0;
    end else begin
      state_q <= state_nxt;
      idx_q   <= idx_nxt;
      pend    <= pend_nxt;
      ovf     <= ovf_nxt;
    end
  end

  // Driven straight from the state flop so reset drops it asynchronously.
  assign irq_valid = (state_q == PRESENT);
  assign irq_idx   = idx_q;

endmodule

// File: tb/tb_irq_pending_latch.sv
module tb_irq_pending_latch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_in, edge_sel, mask;
  logic       irq_ack, ovf_clr;
  logic       irq_valid;
  logic [1:0] irq_idx;
  logic [3:0] pend, ovf;

  int tests_run = 0;
  int failed    = 0;

  irq_pending_latch #(.N(4), .IDX_W(2), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_in    (req_in),
    .edge_sel  (edge_sel),
    .mask      (mask),
    .irq_ack   (irq_ack),
    .ovf_clr   (ovf_clr),
    .irq_valid (irq_valid),
    .irq_idx   (irq_idx),
    .pend      (pend),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs are driven and outputs sampled 1ns later.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    req_in   = '0;
    edge_sel = 4'b1111;
    mask     = 4'b1111;
    irq_ack  = 1'b0;
    ovf_clr  = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    req_in   = '0;
    edge_sel = 4'b1111;
    mask     = 4'b1111;
    irq_ack  = 1'b0;
    ovf_clr  = 1'b0;
    tick(2);
    tests_run++;
    if ({irq_valid, irq_idx, pend, ovf} !== 11'b0) begin
      failed++;
      $display("FAIL reset_state: got valid=%b idx=%b pend=%b ovf=%b, want all zero",
               irq_valid, irq_idx, pend, ovf);
    end
    rst_n = 1'b1;
    tick(3);
    tests_run++;
    if ({irq_valid, pend, ovf} !== 9'b0) begin
      failed++;
      $display("FAIL reset_release_idle: got valid=%b pend=%b ovf=%b, want zeros",
               irq_valid, pend, ovf);
    end
  endtask

  task automatic test_single_edge();
    do_reset();
    req_in = 4'b0010;
    tick(1);               // edge 1: first sync stage
    req_in = 4'b0000;
    tick(1);               // edge 2: req_s
    tests_run++;
    if (pend !== 4'b0000) begin
      failed++;
      $display("FAIL single_pend_early: got %b want 0000", pend);
    end
    tick(1);               // edge 3: pend
    tests_run++;
    if (pend !== 4'b0010 || irq_valid !== 1'b0) begin
      failed++;
      $display("FAIL single_pend_c3: got pend=%b valid=%b want 0010/0", pend, irq_valid);
    end
    tick(1);               // edge 4: presented
    tests_run++;
    if (irq_valid !== 1'b1 || irq_idx !== 2'b01) begin
      failed++;
      $display("FAIL single_present_c4: got valid=%b idx=%b want 1/01", irq_valid, irq_idx);
    end
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    tests_run++;
    if (pend !== 4'b0000 || irq_valid !== 1'b0) begin
      failed++;
      $display("FAIL single_ack: got pend=%b valid=%b want 0000/0", pend, irq_valid);
    end
  endtask

  task automatic test_ack_ignored();
    do_reset();
    mask   = 4'b0000;
    req_in = 4'b0100;
    tick(1);
    req_in = 4'b0000;
    tick(3);
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    tests_run++;
    if (pend !== 4'b0100 || irq_valid !== 1'b0) begin
      failed++;
      $display("FAIL ack_while_idle: got pend=%b valid=%b want 0100/0", pend, irq_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_idx [3];
    logic [3:0] exp_pend [3];
    exp_idx[0]  = 2'b11; exp_idx[1]  = 2'b01; exp_idx[2]  = 2'b00;
    exp_pend[0] = 4'b0011; exp_pend[1] = 4'b0001; exp_pend[2] = 4'b0000;
    do_reset();
    req_in = 4'b1011;
    tick(1);
    req_in = 4'b0000;
    tick(2);
    tests_run++;
    if (pend !== 4'b1011) begin
      failed++;
      $display("FAIL b2b_pend: got %b want 1011", pend);
    end
    for (int g = 0; g < 3; g++) begin
      tick(1);
      tests_run++;
      if (irq_valid !== 1'b1 || irq_idx !== exp_idx[g]) begin
        failed++;
        $display("FAIL b2b_grant%0d: got valid=%b idx=%b want 1/%b",
                 g, irq_valid, irq_idx, exp_idx[g]);
      end
      irq_ack = 1'b1;
      tick(1);
      irq_ack = 1'b0;
      tests_run++;
      if (irq_valid !== 1'b0 || pend !== exp_pend[g]) begin
        failed++;
        $display("FAIL b2b_idle%0d: got valid=%b pend=%b want 0/%b",
                 g, irq_valid, pend, exp_pend[g]);
      end
    end
  endtask

  task automatic test_mask();
    do_reset();
    mask   = 4'b0111;
    req_in = 4'b1100;
    tick(1);
    req_in = 4'b0000;
    tick(3);
    tests_run++;
    if (irq_valid !== 1'b1 || irq_idx !== 2'b10) begin
      failed++;
      $display("FAIL mask_present2: got valid=%b idx=%b want 1/10", irq_valid, irq_idx);
    end
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    tick(1);
    tests_run++;
    if (pend !== 4'b1000 || irq_valid !== 1'b0) begin
      failed++;
      $display("FAIL mask_held: got pend=%b valid=%b want 1000/0", pend, irq_valid);
    end
    mask = 4'b1111;
    tick(1);
    tests_run++;
    if (irq_valid !== 1'b1 || irq_idx !== 2'b11) begin
      failed++;
      $display("FAIL mask_unmask: got valid=%b idx=%b want 1/11", irq_valid, irq_idx);
    end
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    req_in = 4'b0001;
    tick(1);
    req_in = 4'b0000;
    tick(2);               // pend[0] set here
    req_in = 4'b0001;
    tick(1);
    req_in = 4'b0000;
    tick(1);
    tests_run++;
    if (ovf !== 4'b0000) begin
      failed++;
      $display("FAIL ovf_early: got %b want 0000", ovf);
    end
    tick(1);
    tests_run++;
    if (ovf !== 4'b0001 || pend !== 4'b0001) begin
      failed++;
      $display("FAIL ovf_set: got ovf=%b pend=%b want 0001/0001", ovf, pend);
    end
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    tests_run++;
    if (ovf !== 4'b0000) begin
      failed++;
      $display("FAIL ovf_clr: got %b want 0000", ovf);
    end
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    tests_run++;
    if (pend !== 4'b0000 || irq_valid !== 1'b0) begin
      failed++;
      $display("FAIL ovf_ack: got pend=%b valid=%b want 0000/0", pend, irq_valid);
    end
  endtask

  task automatic test_level_and_async_reset();
    do_reset();
    edge_sel = 4'b1011;
    req_in   = 4'b0100;
    tick(4);
    tests_run++;
    if (irq_valid !== 1'b1 || irq_idx !== 2'b10) begin
      failed++;
      $display("FAIL level_present: got valid=%b idx=%b want 1/10", irq_valid, irq_idx);
    end
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    tests_run++;
    if (irq_valid !== 1'b0 || pend !== 4'b0100) begin
      failed++;
      $display("FAIL level_repend: got valid=%b pend=%b want 0/0100", irq_valid, pend);
    end
    tick(1);
    tests_run++;
    if (irq_valid !== 1'b1 || irq_idx !== 2'b10) begin
      failed++;
      $display("FAIL level_represent: got valid=%b idx=%b want 1/10", irq_valid, irq_idx);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (irq_valid !== 1'b0 || pend !== 4'b0000 || ovf !== 4'b0000) begin
      failed++;
      $display("FAIL async_reset: got valid=%b pend=%b ovf=%b want 0/0000/0000",
               irq_valid, pend, ovf);
    end
    req_in   = 4'b0000;
    edge_sel = 4'b1111;
    tick(1);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    test_reset();
    test_single_edge();
    test_ack_ignored();
    test_back_to_back();
    test_mask();
    test_overflow();
    test_level_and_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
